// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the switch debouncer family.
package debounce_pkg;

    localparam int DEBOUNCE_LIMIT_10MS = 250000;    // 10 ms at 25 MHz
    localparam int HOLD_LIMIT_1S       = 25000000;  // 1 s at 25 MHz

    // Counter width able to hold 0..value, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: 2-flop synchroniser, stability counter, registered level,
// press/release pulses and a saturating long-press detector.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_10MS,
    parameter int   HOLD_LIMIT     = HOLD_LIMIT_1S,
    parameter logic INIT_STATE     = 1'b0
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall,
    output logic o_Hold
);

    localparam int             DCW     = clog2_min1(DEBOUNCE_LIMIT);
    localparam logic [DCW-1:0] DB_LAST = DCW'(DEBOUNCE_LIMIT - 1);

    logic           sync_p1, sync_p2;
    logic [DCW-1:0] db_cnt, db_cnt_nxt;
    logic           level_nxt, rise_nxt, fall_nxt;

    // Synchroniser stage: only sync_p2 is safe to use.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync_p1 <= INIT_STATE;
            sync_p2 <= INIT_STATE;
        end else begin
            sync_p1 <= i_Switch;
            sync_p2 <= sync_p1;
        end
    end

    always_comb begin
        db_cnt_nxt = '0;
        level_nxt  = o_Switch;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        if (sync_p2 != o_Switch) begin
            if (db_cnt == DB_LAST) begin
                level_nxt = sync_p2;
                rise_nxt  = sync_p2;
                fall_nxt  = ~sync_p2;
            end else begin
                db_cnt_nxt = db_cnt + DCW'(1);
            end
        end
    end

    // Level stage: pulses register alongside the level they announce.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            db_cnt   <= '0;
            o_Switch <= INIT_STATE;
            o_Rise   <= 1'b0;
            o_Fall   <= 1'b0;
        end else begin
            db_cnt   <= db_cnt_nxt;
            o_Switch <= level_nxt;
            o_Rise   <= rise_nxt;
            o_Fall   <= fall_nxt;
        end
    end

    generate
        if (HOLD_LIMIT == 0) begin : g_no_hold
            assign o_Hold = 1'b0;
        end else begin : g_hold
            localparam int             HCW   = clog2_min1(HOLD_LIMIT);
            localparam logic [HCW-1:0] H_MAX = HCW'(HOLD_LIMIT);

            logic [HCW-1:0] hold_cnt, hold_cnt_nxt;

            // Counter sits at 0 through the rise cycle because the level was still 0.
            always_comb begin
                hold_cnt_nxt = '0;
                if (o_Switch)
                    hold_cnt_nxt = (hold_cnt == H_MAX) ? hold_cnt : hold_cnt + HCW'(1);
            end

            // Hold stage: qualified by the next level so it drops with o_Fall.
            always_ff @(posedge i_Clk) begin
                if (i_Reset) begin
                    hold_cnt <= '0;
                    o_Hold   <= 1'b0;
                end else begin
                    hold_cnt <= hold_cnt_nxt;
                    o_Hold   <= level_nxt && (hold_cnt_nxt == H_MAX);
                end
            end
        end
    endgenerate

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel switch debouncer: NUM_CH independent debounce_channel instances.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   NUM_CH         = 4,
    parameter int   DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_10MS,
    parameter int   HOLD_LIMIT     = HOLD_LIMIT_1S,
    parameter logic INIT_STATE     = 1'b0
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_CH-1:0] i_Switch,
    output logic [NUM_CH-1:0] o_Switch,
    output logic [NUM_CH-1:0] o_Rise,
    output logic [NUM_CH-1:0] o_Fall,
    output logic [NUM_CH-1:0] o_Hold
);

    genvar n;
    generate
        for (n = 0; n < NUM_CH; n++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_LIMIT (DEBOUNCE_LIMIT),
                .HOLD_LIMIT     (HOLD_LIMIT),
                .INIT_STATE     (INIT_STATE)
            ) u_ch (
                .i_Clk    (i_Clk),
                .i_Reset  (i_Reset),
                .i_Switch (i_Switch[n]),
                .o_Switch (o_Switch[n]),
                .o_Rise   (o_Rise[n]),
                .o_Fall   (o_Fall[n]),
                .o_Hold   (o_Hold[n])
            );
        end
    endgenerate

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
Parametrised multi-channel switch debouncer, the successor to the single-channel debounce used ahead of the display/LED logic. Each channel has:
- 2-flop synchroniser
- per-channel stability counter
- registered debounced level
- one-cycle press/release pulses
- long-press (hold) flag

Sits between raw board switch pins and any control FSM that needs clean levels or edge events.

Parameters:
- NUM_CH, 4, number of independent switch channels (>=1)
- DEBOUNCE_LIMIT, 250000, consecutive differing samples required before the debounced level changes (>=1)
- HOLD_LIMIT, 25000000, cycles the debounced level must stay at 1 before o_Hold asserts; 0 disables hold detection (o_Hold tied 0)
- INIT_STATE, 1'b0, reset value of synchronisers and debounced level (all channels)

Ports:
- i_Clk, input, 1, system clock
- i_Reset, input, 1, synchronous active-high reset
- i_Switch, input, NUM_CH, raw asynchronous switch inputs, bit n = channel n
- o_Switch, output, NUM_CH, debounced level per channel
- o_Rise, output, NUM_CH, one-cycle pulse when o_Switch[n] goes 0->1
- o_Fall, output, NUM_CH, one-cycle pulse when o_Switch[n] goes 1->0
- o_Hold, output, NUM_CH, level; 1 while o_Switch[n]=1 has persisted >= HOLD_LIMIT cycles

Behaviour:
- Clock and reset: one clock, i_Clk. Reset is synchronous, active-high, on i_Reset, sampled at posedge i_Clk. All state is reset by it.
- Reset values:
  - sync flops = INIT_STATE
  - o_Switch = INIT_STATE
  - debounce counters = 0
  - hold counters = 0
  - o_Rise = o_Fall = o_Hold = 0
  - No edge pulse is generated by reset entry or exit, and reset overrides every other event in the same cycle.
- Synchroniser: i_Switch[n] -> s1[n] -> s2[n]. Only s2 feeds the debounce logic.
- Debounce counter, width $clog2(DEBOUNCE_LIMIT+1), per channel, each cycle:
  - s2 == o_Switch: counter <= 0.
  - s2 != o_Switch and counter < DEBOUNCE_LIMIT-1: counter <= counter+1.
  - s2 != o_Switch and counter == DEBOUNCE_LIMIT-1: o_Switch <= s2, counter <= 0.
  - Net effect: the level changes after exactly DEBOUNCE_LIMIT consecutive differing samples. Any single agreeing sample restarts the count. The counter never exceeds DEBOUNCE_LIMIT-1 and never wraps.
- Latency: a clean step on i_Switch, set up before edge 1, appears on o_Switch after edge DEBOUNCE_LIMIT+2.
- Edge pulses:
  - o_Rise[n] and o_Fall[n] are registered.
  - Each is asserted for exactly the one cycle in which o_Switch[n] shows its new value, i.e. coincident with the updated level.
  - They are never both 1 on the same channel.
- Hold counter, width $clog2(HOLD_LIMIT+1), saturating:
  - Cleared whenever o_Switch[n]=0, and in the cycle o_Rise[n] is asserted.
  - Increments while o_Switch[n]=1 and counter < HOLD_LIMIT.
  - o_Hold[n] is a registered 1 once the counter reaches HOLD_LIMIT, and stays 1 until o_Switch[n] falls.
  - o_Hold[n] drops in the same cycle o_Fall[n] pulses.
- Channel independence: no cross-channel coupling. Simultaneous transitions on several channels are each handled independently in the same cycle.
- Glitch shorter than DEBOUNCE_LIMIT samples: no change on o_Switch and no pulses; the counter returns to 0.
- Reset mid-count: counters clear and o_Switch returns to INIT_STATE even if the input is held. After release, a held input different from INIT_STATE re-debounces fully (DEBOUNCE_LIMIT+2 cycles) and produces the corresponding edge pulse.
- DEBOUNCE_LIMIT=1: the level follows s2 with one cycle of delay; pulses are still correct.

Decomposition:
- Shared package debounce_pkg holds:
  - function clog2_min1(value) returning max(1,$clog2(value+1)), used for counter widths
  - default limit constants DEBOUNCE_LIMIT_10MS=250000 and HOLD_LIMIT_1S=25000000 (25 MHz board clock)
- One sub-module: debounce_channel. It contains the synchroniser, debounce counter, level, edge pulses and hold counter for one bit.
- debounce_multi instantiates NUM_CH copies in a generate loop. The bench can also test debounce_channel standalone.

Test Plan:
All scenarios use NUM_CH=2, DEBOUNCE_LIMIT=4, HOLD_LIMIT=10, INIT_STATE=0.
1. Reset, then i_Switch=2'b00 held for 20 cycles -> o_Switch=00, no o_Rise/o_Fall/o_Hold pulses, including at reset release.
2. ch0 steps 0->1 before edge 1 -> o_Switch[0]=1 and o_Rise[0]=1 after edge 6, o_Rise[0]=0 after edge 7; ch1 unaffected.
3. ch0 bounce 1,1,1,0 repeated (3 high, 1 low) for 40 cycles -> o_Switch[0] stays 0, no pulses.
4. ch1 held at 1 -> o_Rise[1] at cycle 6, o_Hold[1]=1 at cycle 16 and held; release -> o_Fall[1] pulse and o_Hold[1]=0 together 6 cycles later.
5. Both channels step to 1 in the same cycle -> o_Rise=2'b11 in the same single cycle.
6. ch0 held at 1, i_Reset pulsed for 1 cycle at cycle 4 (mid-count) -> o_Switch[0]=0 through reset; after release, o_Rise[0] pulses 6 cycles later.
